uart_rx_rr_collector: RTL
=========================

# uart_rx_rr_collector

Round-robin read scheduler for the receive side of the multi-channel UART wrapper. It polls the per-channel RX FIFO empty flags and issues bounded read bursts, one channel at a time. Bytes from all channels merge into a single valid/ready byte stream, each byte tagged with its source channel. Upstream of the PCIe/host interface, the host therefore sees one RX stream instead of UART_NUM FIFO read ports.

## Interface
- UART_NUM, 6, number of UART channels served (1..16, need not be a power of two)
- CH_W, 3, width of channel tag; must satisfy 2^CH_W >= UART_NUM
- MAX_BURST, 16, maximum bytes read from one channel per grant (1..255)

- sys_clk_i  in  1  single clock for all logic, same domain as the RX FIFO read ports
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  global enable; 0 = no new grants, no new reads
- chan_mask_i  in  UART_NUM  per-channel enable, 1 = channel eligible
- fifo_uart_rx_empty  in  UART_NUM  RX FIFO empty flags
- uart_rx_data  in  UART_NUM*8  RX FIFO read data, channel i at [8*i+7:8*i]
- fifo_uart_rx_rden  out  UART_NUM  RX FIFO read enables, at most one bit high
- m_valid_o  out  1  output byte valid
- m_ready_i  in  1  output byte accepted when m_valid_o & m_ready_i
- m_data_o  out  8  output byte
- m_chan_o  out  CH_W  source channel of m_data_o
- busy_o  out  1  grant active, read in flight, or output buffer non-empty

## Operation
- RX FIFO contract: standard (non-FWFT). Data for a read issued in cycle t is valid on uart_rx_data in cycle t+1 only.
- Internal 2-entry output FIFO. Each entry holds {channel, byte}; its head drives m_data_o/m_chan_o. m_valid_o = occupancy != 0.
- Credit rule: a read may be issued in cycle t only if occupancy(t) + inflight(t) < 2. inflight is 1 if a read was issued in t-1. The buffer never overflows.
- State machine IDLE / READ.
- IDLE: eligible = chan_mask_i & ~fifo_uart_rx_empty, and enable_i = 1.
  - If any channel is eligible, grant the first eligible channel searching upward from rr_ptr with wrap UART_NUM-1 -> 0.
  - Latch grant g, clear burst_cnt, go to READ.
- READ: fifo_uart_rx_rden[g] is combinational from registered state = READ, burst_cnt < MAX_BURST, ~fifo_uart_rx_empty[g], chan_mask_i[g], enable_i, and the credit rule. It is never asserted for an empty FIFO.
- Each read increments burst_cnt. The counter is wide enough to hold MAX_BURST and does not wrap.
- READ -> IDLE when any of these holds: burst_cnt == MAX_BURST, fifo_uart_rx_empty[g], ~chan_mask_i[g], or ~enable_i. On that transition rr_ptr = g+1, wrapping UART_NUM-1 -> 0.
- A read issued in the last READ cycle completes normally. Its byte enters the buffer tagged g, even if a new grant is already active.
- Output handshake: m_data_o/m_chan_o hold stable while m_valid_o & ~m_ready_i. Bytes are never dropped or reordered. Per-channel byte order is preserved.
- Push and pop in the same cycle are allowed; occupancy is unchanged.

## Timing
- Reset (asynchronous, effective immediately): state IDLE, rr_ptr 0, burst_cnt 0, inflight 0, buffer empty. Output values: m_valid_o 0, m_data_o 0x00, m_chan_o 0, fifo_uart_rx_rden 0, busy_o 0.
- Reset mid-burst: an in-flight byte is discarded. The FIFO has already advanced, so that byte is lost; this is accepted.
- Latency with m_ready_i = 1:
  - Eligibility seen in IDLE at cycle G.
  - rden in G+1.
  - Byte in buffer, m_valid_o = 1, at G+3.
- Throughput ceiling: 2 bytes per 3 cycles, set by the credit rule.
- Grant overhead: one IDLE cycle between consecutive bursts.
- m_ready_i held low: at most 2 reads are issued, then rden stays 0 until a pop.
- Simultaneous events:
  - empty[g] rising in the same cycle as the MAX_BURST-th read: the single exit is taken.
  - mask and empty changing together in IDLE: sampled values are used.

## Test plan
- Channel 2 holds 0xA1,0xA2,0xA3, m_ready_i = 1. Expect three outputs in order, all with m_chan_o = 2. First m_valid_o at G+3. rden[2] pulses exactly 3 times and never while empty.
- Channels 0, 1 and 5 each hold 2 bytes, rr_ptr = 0. Expect output channel order 0,0,1,1,5,5. After the burst on channel 5, rr_ptr wraps to 0.
- MAX_BURST = 4; channel 1 holds 10 bytes, channel 3 holds 2. Expect output channel order 1×4, 3×2, 1×4, 1×2. Bytes within each channel stay in order.
- m_ready_i low for 20 cycles while channel 4 holds 8 bytes. Expect at most 2 rden pulses, m_data_o stable throughout, and busy_o = 1. Then release m_ready_i: all 8 bytes arrive in order with no loss.
- chan_mask_i[1] cleared mid-burst. Expect the burst to end, the in-flight byte to still arrive tagged 1, and channel 1 skipped thereafter. With enable_i = 0, expect no rden and the state to stay in IDLE.
- rst_i pulsed during a channel-3 burst. Expect all outputs to go to their reset values without waiting for a clock edge. After release, arbitration restarts from channel 0.

Source files
------------

// File: rtl/uart_rx_rr_collector.sv
// Round-robin RX FIFO read scheduler: bounded bursts per channel, merged into one
// channel-tagged valid/ready byte stream through a 2-entry output buffer.
module uart_rx_rr_collector #(
  parameter int UART_NUM  = 6,
  parameter int CH_W      = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [UART_NUM-1:0]   chan_mask_i,
  input  logic [UART_NUM-1:0]   fifo_uart_rx_empty,
  input  logic [UART_NUM*8-1:0] uart_rx_data,
  output logic [UART_NUM-1:0]   fifo_uart_rx_rden,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [7:0]            m_data_o,
  output logic [CH_W-1:0]       m_chan_o,
  output logic                  busy_o,
  output logic                  dbg_state_o,
  output logic [CH_W-1:0]       dbg_rr_ptr_o
);
  // Output stream: a byte transfers on every cycle with m_valid_o & m_ready_i; while
  // m_valid_o is high and m_ready_i low, m_data_o/m_chan_o hold their value.
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

  state_t           r_state;
  logic [CH_W-1:0]  r_grant;
  logic [CH_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_inflight;
  logic [CH_W-1:0]  r_inflight_ch;
  logic [CH_W+7:0]  r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;

  logic [UART_NUM-1:0]   w_elig;
  logic [2*UART_NUM-1:0] w_rot2;
  logic                  w_found;
  logic [CH_W+1:0]       w_off;
  logic [CH_W+1:0]       w_sum;
  logic [CH_W-1:0]       w_pick;
  logic                  w_g_empty;
  logic                  w_g_mask;
  logic [7:0]            w_rx_byte;
  logic                  w_credit;
  logic                  w_rd;
  logic                  w_exit;
  logic [CH_W-1:0]       w_next_ptr;
  logic                  w_push;
  logic                  w_pop;

  assign w_elig = enable_i ? (chan_mask_i & ~fifo_uart_rx_empty) : '0;

  // Rotate eligibility so bit 0 is rr_ptr; the lowest set bit is the next grant.
  always_comb begin
    w_rot2  = {w_elig, w_elig} >> r_rr_ptr;
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 2*UART_NUM-1; k >= 0; k--) begin
      if (w_rot2[k]) begin
        w_found = 1'b1;
        w_off   = (CH_W+2)'(k);
      end
    end
    w_sum = {2'b00, r_rr_ptr} + w_off;
    if (w_sum >= (CH_W+2)'(UART_NUM)) w_sum = w_sum - (CH_W+2)'(UART_NUM);
    w_pick = w_sum[CH_W-1:0];
  end

  always_comb begin
    w_g_empty = 1'b1;
    w_g_mask  = 1'b0;
    w_rx_byte = '0;
    for (int i = 0; i < UART_NUM; i++) begin
      if (r_grant == CH_W'(i)) begin
        w_g_empty = fifo_uart_rx_empty[i];
        w_g_mask  = chan_mask_i[i];
      end
      if (r_inflight_ch == CH_W'(i)) w_rx_byte = uart_rx_data[8*i +: 8];
    end
  end

  // Occupancy plus a pending read must leave room, so the buffer never overflows.
  assign w_credit = ({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd2;
  assign w_rd = (r_state == S_READ) && (r_burst_cnt < CNT_W'(MAX_BURST)) &&
                !w_g_empty && w_g_mask && enable_i && w_credit;
  assign w_exit = (r_burst_cnt == CNT_W'(MAX_BURST)) || w_g_empty || !w_g_mask || !enable_i;
  assign w_next_ptr = (r_grant == CH_W'(UART_NUM-1)) ? '0 : r_grant + CH_W'(1);

  always_comb begin
    fifo_uart_rx_rden = '0;
    for (int i = 0; i < UART_NUM; i++) begin
      fifo_uart_rx_rden[i] = w_rd && (r_grant == CH_W'(i));
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          if (w_rd) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          if (w_exit) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_push = r_inflight;
  assign w_pop  = m_valid_o && m_ready_i;

  // The in-flight tag is captured at issue time, so a late byte keeps its channel.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight    <= 1'b0;
      r_inflight_ch <= '0;
      r_mem[0]      <= '0;
      r_mem[1]      <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_occ         <= 2'd0;
    end else begin
      r_inflight <= w_rd;
      if (w_rd) r_inflight_ch <= r_grant;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_inflight_ch, w_rx_byte};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign m_valid_o            = (r_occ != 2'd0);
  assign {m_chan_o, m_data_o} = r_mem[r_rd_ptr];
  assign busy_o               = (r_state == S_READ) || r_inflight || (r_occ != 2'd0);
  assign dbg_state_o          = (r_state == S_READ);
  assign dbg_rr_ptr_o         = r_rr_ptr;

endmodule
